// File: rtl/plic_gateway_multi_if.sv
// Bundle between the PLIC register block (master) and the gateway (slave).
//   irq_src_i       raw asynchronous source lines
//   mode_i          per-source trigger mode: 00 level-high, 01 rise, 10 fall, 11 both
//   claim_req_i     one-cycle claim strobe per target; claim_idx_i carries the ID
//   complete_req_i  one-cycle complete strobe per target; complete_idx_i carries the ID
//   overflow_clr_i  clears the matching sticky overflow flags
//   irq_pending_o   source pending toward the PLIC core
//   irq_active_o    source claimed and awaiting complete
//   edge_overflow_o sticky flag: an edge was dropped at counter saturation
interface plic_gateway_multi_if #(
  parameter int unsigned SRC_COUNT = 32,
  parameter int unsigned TGT_COUNT = 2,
  parameter int unsigned SRC_WIDTH = $clog2(SRC_COUNT + 1)
);
  logic [SRC_COUNT-1:0]                irq_src_i;
  logic [SRC_COUNT-1:0][1:0]           mode_i;
  logic [TGT_COUNT-1:0]                claim_req_i;
  logic [TGT_COUNT-1:0][SRC_WIDTH-1:0] claim_idx_i;
  logic [TGT_COUNT-1:0]                complete_req_i;
  logic [TGT_COUNT-1:0][SRC_WIDTH-1:0] complete_idx_i;
  logic [SRC_COUNT-1:0]                overflow_clr_i;
  logic [SRC_COUNT-1:0]                irq_pending_o;
  logic [SRC_COUNT-1:0]                irq_active_o;
  logic [SRC_COUNT-1:0]                edge_overflow_o;

  modport master (
    output irq_src_i, mode_i, claim_req_i, claim_idx_i,
           complete_req_i, complete_idx_i, overflow_clr_i,
    input  irq_pending_o, irq_active_o, edge_overflow_o
  );

  modport slave (
    input  irq_src_i, mode_i, claim_req_i, claim_idx_i,
           complete_req_i, complete_idx_i, overflow_clr_i,
    output irq_pending_o, irq_active_o, edge_overflow_o
  );
endinterface

// File: rtl/plic_gateway_multi.sv
// PLIC gateway: synchronizes raw interrupt lines, detects edges per source
// trigger mode, queues edges that arrive while a source is busy, and tracks
// each source through IDLE -> PENDING -> ACTIVE via target claim/complete.
//   clk  clock
//   rst  synchronous reset, active-high
//   gw   slave side of plic_gateway_multi_if (sources, modes, claim/complete,
//        overflow clear in; pending, active, overflow flags out)
module plic_gateway_multi #(
  parameter int unsigned SRC_COUNT      = 32,
  parameter int unsigned TGT_COUNT      = 2,
  parameter int unsigned SRC_WIDTH      = $clog2(SRC_COUNT + 1),
  parameter int unsigned EDGE_CNT_WIDTH = 3,
  parameter int unsigned SYNC_STAGES    = 2
) (
  input logic                  clk,
  input logic                  rst,
  plic_gateway_multi_if.slave  gw
);

  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [EDGE_CNT_WIDTH-1:0] CNT_ONE = EDGE_CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACTIVE  = 2'd2
  } state_t;

  logic [SRC_COUNT-1:0]      sync_q [SYNC_STAGES];
  logic [SRC_COUNT-1:0]      prev_q;
  logic [SRC_COUNT-1:0][1:0] mode_q;
  logic [EDGE_CNT_WIDTH-1:0] cnt_q  [SRC_COUNT];
  state_t                    state_q[SRC_COUNT];
  logic [SRC_COUNT-1:0]      pending_q;
  logic [SRC_COUNT-1:0]      active_q;
  logic [SRC_COUNT-1:0]      overflow_q;

  logic [SRC_COUNT-1:0]      s_c;
  logic [SRC_COUNT-1:0]      rise_c;
  logic [SRC_COUNT-1:0]      fall_c;
  logic [SRC_COUNT-1:0]      edge_c;
  logic [SRC_COUNT-1:0]      claim_hit_c;
  logic [SRC_COUNT-1:0]      complete_hit_c;

  assign s_c    = sync_q[SYNC_STAGES-1];
  assign rise_c = s_c & ~prev_q;
  assign fall_c = ~s_c & prev_q;

  // Mode-qualified edge and per-source claim/complete decode. IDs outside
  // 1..SRC_COUNT never match any source, so they fall out naturally.
  always_comb begin
    edge_c         = '0;
    claim_hit_c    = '0;
    complete_hit_c = '0;
    for (int unsigned i = 0; i < SRC_COUNT; i++) begin
      unique case (gw.mode_i[i])
        2'b01:   edge_c[i] = rise_c[i];
        2'b10:   edge_c[i] = fall_c[i];
        2'b11:   edge_c[i] = rise_c[i] | fall_c[i];
        default: edge_c[i] = 1'b0;
      endcase
      for (int unsigned t = 0; t < TGT_COUNT; t++) begin
        if (gw.claim_req_i[t] && (gw.claim_idx_i[t] == SRC_WIDTH'(i + 1)))
          claim_hit_c[i] = 1'b1;
        if (gw.complete_req_i[t] && (gw.complete_idx_i[t] == SRC_WIDTH'(i + 1)))
          complete_hit_c[i] = 1'b1;
      end
    end
  end

  // Synchronizer, edge history, per-source FSM, edge counter and overflow flag.
  // Later non-blocking assignments to the same counter/flag take precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
      prev_q     <= '0;
      mode_q     <= '0;
      pending_q  <= '0;
      active_q   <= '0;
      overflow_q <= '0;
      for (int unsigned i = 0; i < SRC_COUNT; i++) begin
        cnt_q[i]   <= '0;
        state_q[i] <= ST_IDLE;
      end
    end else begin
      sync_q[0] <= gw.irq_src_i;
      for (int unsigned j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
      prev_q <= s_c;
      mode_q <= gw.mode_i;

      for (int unsigned i = 0; i < SRC_COUNT; i++) begin
        unique case (state_q[i])
          ST_IDLE: begin
            if ((gw.mode_i[i] == 2'b00) ? s_c[i] : (edge_c[i] || (cnt_q[i] != '0))) begin
              state_q[i]   <= ST_PENDING;
              pending_q[i] <= 1'b1;
            end
            // A fresh edge is consumed first; only otherwise drain the queue.
            if ((gw.mode_i[i] != 2'b00) && !edge_c[i] && (cnt_q[i] != '0))
              cnt_q[i] <= cnt_q[i] - CNT_ONE;
          end
          ST_PENDING: begin
            if (claim_hit_c[i]) begin
              state_q[i]   <= ST_ACTIVE;
              pending_q[i] <= 1'b0;
              active_q[i]  <= 1'b1;
            end
          end
          ST_ACTIVE: begin
            if (complete_hit_c[i]) begin
              state_q[i]  <= ST_IDLE;
              active_q[i] <= 1'b0;
            end
          end
          default: begin
            state_q[i]   <= ST_IDLE;
            pending_q[i] <= 1'b0;
            active_q[i]  <= 1'b0;
          end
        endcase

        if (gw.overflow_clr_i[i]) overflow_q[i] <= 1'b0;

        // Edges seen while busy are queued; at saturation they set the flag.
        if ((state_q[i] != ST_IDLE) && edge_c[i]) begin
          if (cnt_q[i] == CNT_MAX) overflow_q[i] <= 1'b1;
          else                     cnt_q[i]      <= cnt_q[i] + CNT_ONE;
        end

        if ((gw.mode_i[i] == 2'b00) || (gw.mode_i[i] != mode_q[i]))
          cnt_q[i] <= '0;
      end
    end
  end

  assign gw.irq_pending_o   = pending_q;
  assign gw.irq_active_o    = active_q;
  assign gw.edge_overflow_o = overflow_q;

endmodule

// File: tb/tb_plic_gateway_multi.sv
// Bench for plic_gateway_multi: a reference model predicts the output vectors
// at every clock edge and queues them; a monitor on the falling edge pops and
// compares. Directed scenarios are followed by a randomized phase.
module tb_plic_gateway_multi;

  localparam int unsigned SRC  = 32;
  localparam int unsigned TGT  = 2;
  localparam int unsigned SW   = 6;
  localparam int unsigned CW   = 3;
  localparam int unsigned SS   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_PEND = 1;
  localparam int M_ACT  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  plic_gateway_multi_if #(.SRC_COUNT(SRC), .TGT_COUNT(TGT), .SRC_WIDTH(SW)) gw_if ();

  plic_gateway_multi #(
    .SRC_COUNT(SRC), .TGT_COUNT(TGT), .SRC_WIDTH(SW),
    .EDGE_CNT_WIDTH(CW), .SYNC_STAGES(SS)
  ) dut (
    .clk(clk),
    .rst(rst),
    .gw (gw_if)
  );

  typedef struct packed {
    logic [SRC-1:0] pend;
    logic [SRC-1:0] act;
    logic [SRC-1:0] ovf;
  } snap_t;

  snap_t exp_q[$];
  int total = 0;
  int bad   = 0;

  // Reference model state
  int m_st   [SRC];
  int m_cnt  [SRC];
  bit m_ovf  [SRC];
  bit m_pv   [SRC];
  int m_mprev[SRC];
  bit m_sh   [SRC][SS];

  function automatic void cmp_vec(string nm, logic [SRC-1:0] a, logic [SRC-1:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h t=%0t", nm, a, e, $time);
    end
  endfunction

  function automatic void cmp_bit(string nm, logic a, logic e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%b required=%b t=%0t", nm, a, e, $time);
    end
  endfunction

  // Behavioural model: evaluates the gateway rules at every rising edge.
  always @(posedge clk) begin : ref_model
    snap_t e;
    int s, p, m, edg, hitc, hitd, nst, ncnt, setf;
    if (rst) begin
      for (int i = 0; i < SRC; i++) begin
        m_st[i] = M_IDLE; m_cnt[i] = 0; m_ovf[i] = 0; m_pv[i] = 0; m_mprev[i] = 0;
        for (int j = 0; j < SS; j++) m_sh[i][j] = 0;
      end
    end else begin
      for (int i = 0; i < SRC; i++) begin
        s = int'(m_sh[i][SS-1]);
        p = int'(m_pv[i]);
        m = int'(gw_if.mode_i[i]);
        case (m)
          1:       edg = (s == 1 && p == 0) ? 1 : 0;
          2:       edg = (s == 0 && p == 1) ? 1 : 0;
          3:       edg = (s != p) ? 1 : 0;
          default: edg = 0;
        endcase
        hitc = 0; hitd = 0;
        for (int t = 0; t < TGT; t++) begin
          if (gw_if.claim_req_i[t] && int'(gw_if.claim_idx_i[t]) == i + 1) hitc = 1;
          if (gw_if.complete_req_i[t] && int'(gw_if.complete_idx_i[t]) == i + 1) hitd = 1;
        end
        nst = m_st[i]; ncnt = m_cnt[i]; setf = 0;
        if (m_st[i] == M_IDLE) begin
          if (m == 0) begin
            if (s == 1) nst = M_PEND;
          end else if (edg == 1) begin
            nst = M_PEND;
          end else if (m_cnt[i] > 0) begin
            nst = M_PEND;
            ncnt = m_cnt[i] - 1;
          end
        end else if (edg == 1) begin
          if (m_cnt[i] >= CMAX) setf = 1;
          else ncnt = m_cnt[i] + 1;
        end
        if (m_st[i] == M_PEND && hitc == 1) nst = M_ACT;
        if (m_st[i] == M_ACT && hitd == 1) nst = M_IDLE;
        if (m == 0 || m != m_mprev[i]) ncnt = 0;
        if (setf == 1) m_ovf[i] = 1;
        else if (gw_if.overflow_clr_i[i]) m_ovf[i] = 0;
        m_st[i] = nst;
        m_cnt[i] = ncnt;
        m_pv[i] = m_sh[i][SS-1];
        for (int j = SS - 1; j > 0; j--) m_sh[i][j] = m_sh[i][j-1];
        m_sh[i][0] = gw_if.irq_src_i[i];
        m_mprev[i] = m;
      end
    end
    for (int i = 0; i < SRC; i++) begin
      e.pend[i] = (m_st[i] == M_PEND);
      e.act[i]  = (m_st[i] == M_ACT);
      e.ovf[i]  = m_ovf[i];
    end
    exp_q.push_back(e);
  end

  // Monitor: one snapshot per cycle, compared away from the active edge.
  always @(negedge clk) begin : monitor
    snap_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp_vec("sb_pending",  gw_if.irq_pending_o,   e.pend);
      cmp_vec("sb_active",   gw_if.irq_active_o,    e.act);
      cmp_vec("sb_overflow", gw_if.edge_overflow_o, e.ovf);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic do_claim(input int t, input int idx);
    gw_if.claim_req_i[t] = 1'b1;
    gw_if.claim_idx_i[t] = SW'(idx);
    tick();
    gw_if.claim_req_i[t] = 1'b0;
  endtask

  task automatic do_complete(input int t, input int idx);
    gw_if.complete_req_i[t] = 1'b1;
    gw_if.complete_idx_i[t] = SW'(idx);
    tick();
    gw_if.complete_req_i[t] = 1'b0;
  endtask

  function automatic int pick(input int want);
    int lst[$];
    for (int i = 0; i < SRC; i++) if (m_st[i] == want) lst.push_back(i + 1);
    if (lst.size() == 0) return int'($urandom_range(0, 40));
    return lst[$urandom_range(0, lst.size() - 1)];
  endfunction

  initial begin : watchdog
    #2000000;
    bad++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    gw_if.irq_src_i      = '0;
    gw_if.mode_i         = '0;
    gw_if.claim_req_i    = '0;
    gw_if.claim_idx_i    = '0;
    gw_if.complete_req_i = '0;
    gw_if.complete_idx_i = '0;
    gw_if.overflow_clr_i = '0;
    rst = 1'b1;
    ticks(2);
    cmp_vec("reset_pending", gw_if.irq_pending_o, '0);
    cmp_vec("reset_active",  gw_if.irq_active_o,  '0);
    rst = 1'b0;

    // src3 rising edge: pending exactly SS edges after stage-1 sampling
    gw_if.mode_i[2] = 2'b01;
    gw_if.irq_src_i[2] = 1'b1;
    tick();
    cmp_bit("s1_pend_k", gw_if.irq_pending_o[2], 1'b0);
    tick();
    cmp_bit("s1_pend_k1", gw_if.irq_pending_o[2], 1'b0);
    tick();
    cmp_bit("s1_pend_k2", gw_if.irq_pending_o[2], 1'b1);
    gw_if.irq_src_i[2] = 1'b0;
    do_claim(0, 3);
    cmp_bit("s1_claim_act", gw_if.irq_active_o[2], 1'b1);
    cmp_bit("s1_claim_pend", gw_if.irq_pending_o[2], 1'b0);
    do_complete(0, 3);
    cmp_bit("s1_done_act", gw_if.irq_active_o[2], 1'b0);
    ticks(3);
    cmp_bit("s1_quiet", gw_if.irq_pending_o[2], 1'b0);

    // src5 both edges: 4 toggles while active re-pend 4 times
    gw_if.mode_i[4] = 2'b11;
    gw_if.irq_src_i[4] = 1'b1;
    ticks(3);
    cmp_bit("s2_pend", gw_if.irq_pending_o[4], 1'b1);
    do_claim(1, 5);
    for (int k = 0; k < 4; k++) begin
      gw_if.irq_src_i[4] = ~gw_if.irq_src_i[4];
      tick();
    end
    ticks(3);
    for (int r = 0; r < 4; r++) begin
      do_complete(1, 5);
      cmp_bit("s2_idle_act", gw_if.irq_active_o[4], 1'b0);
      tick();
      cmp_bit("s2_repend", gw_if.irq_pending_o[4], 1'b1);
      do_claim(1, 5);
    end
    do_complete(1, 5);
    ticks(2);
    cmp_bit("s2_drained", gw_if.irq_pending_o[4], 1'b0);

    // src1 falling edges: 9 edges while active saturate a 3-bit queue
    gw_if.mode_i[0] = 2'b10;
    gw_if.irq_src_i[0] = 1'b1;
    ticks(3);
    cmp_bit("s3_rise_ign", gw_if.irq_pending_o[0], 1'b0);
    gw_if.irq_src_i[0] = 1'b0;
    ticks(3);
    cmp_bit("s3_pend", gw_if.irq_pending_o[0], 1'b1);
    do_claim(0, 1);
    for (int k = 0; k < 9; k++) begin
      gw_if.irq_src_i[0] = 1'b1; tick();
      gw_if.irq_src_i[0] = 1'b0; tick();
    end
    ticks(3);
    cmp_bit("s3_ovf_set", gw_if.edge_overflow_o[0], 1'b1);
    gw_if.overflow_clr_i[0] = 1'b1;
    tick();
    gw_if.overflow_clr_i[0] = 1'b0;
    cmp_bit("s3_ovf_clr", gw_if.edge_overflow_o[0], 1'b0);
    for (int r = 0; r < CMAX; r++) begin
      do_complete(0, 1);
      tick();
      cmp_bit("s3_repend", gw_if.irq_pending_o[0], 1'b1);
      do_claim(0, 1);
    end
    do_complete(0, 1);
    ticks(2);
    cmp_bit("s3_drained", gw_if.irq_pending_o[0], 1'b0);

    // src2 level: re-pends one cycle after complete while line high
    gw_if.irq_src_i[1] = 1'b1;
    ticks(3);
    cmp_bit("s4_pend", gw_if.irq_pending_o[1], 1'b1);
    do_claim(1, 2);
    do_complete(0, 2);
    cmp_bit("s4_idle", gw_if.irq_pending_o[1], 1'b0);
    tick();
    cmp_bit("s4_repend", gw_if.irq_pending_o[1], 1'b1);
    do_claim(0, 2);
    gw_if.irq_src_i[1] = 1'b0;
    ticks(3);
    do_complete(0, 2);
    ticks(2);
    cmp_bit("s4_stay_idle", gw_if.irq_pending_o[1], 1'b0);

    // src4: dual claim gives one ACTIVE; out-of-range IDs change nothing
    gw_if.mode_i[3] = 2'b01;
    gw_if.irq_src_i[3] = 1'b1;
    ticks(3);
    gw_if.claim_req_i = 2'b11;
    gw_if.claim_idx_i[0] = SW'(4);
    gw_if.claim_idx_i[1] = SW'(4);
    tick();
    cmp_vec("s5_active", gw_if.irq_active_o, 32'h0000_0008);
    gw_if.claim_idx_i[0] = SW'(0);
    gw_if.claim_idx_i[1] = SW'(33);
    gw_if.complete_req_i = 2'b11;
    gw_if.complete_idx_i[0] = SW'(0);
    gw_if.complete_idx_i[1] = SW'(33);
    tick();
    gw_if.claim_req_i = '0;
    gw_if.complete_req_i = '0;
    cmp_vec("s5_bad_id_act", gw_if.irq_active_o, 32'h0000_0008);
    cmp_vec("s5_bad_id_pend", gw_if.irq_pending_o, '0);
    do_complete(1, 4);

    // src6: reset with an active claim and queued edges discards everything
    gw_if.mode_i[5] = 2'b01;
    gw_if.irq_src_i[5] = 1'b1;
    ticks(3);
    do_claim(0, 6);
    for (int k = 0; k < 7; k++) begin
      gw_if.irq_src_i[5] = ~gw_if.irq_src_i[5];
      tick();
    end
    ticks(3);
    cmp_bit("s6_active", gw_if.irq_active_o[5], 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    cmp_vec("s6_rst_pend", gw_if.irq_pending_o, '0);
    cmp_vec("s6_rst_act",  gw_if.irq_active_o,  '0);
    cmp_vec("s6_rst_ovf",  gw_if.edge_overflow_o, '0);
    do_complete(0, 6);
    cmp_bit("s6_late_cpl", gw_if.irq_active_o[5], 1'b0);
    ticks(4);
    cmp_bit("s6_no_repend", gw_if.irq_pending_o[5], 1'b0);

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      gw_if.irq_src_i = gw_if.irq_src_i ^ ($urandom() & $urandom() & $urandom());
      if ($urandom_range(0, 63) == 0)
        gw_if.mode_i[$urandom_range(0, SRC - 1)] = 2'($urandom());
      for (int t = 0; t < TGT; t++) begin
        gw_if.claim_req_i[t] = ($urandom_range(0, 2) == 0);
        gw_if.claim_idx_i[t] = SW'(($urandom_range(0, 1) == 0) ? pick(M_PEND)
                                                                : int'($urandom_range(0, 40)));
        gw_if.complete_req_i[t] = ($urandom_range(0, 2) == 0);
        gw_if.complete_idx_i[t] = SW'(($urandom_range(0, 1) == 0) ? pick(M_ACT)
                                                                   : int'($urandom_range(0, 40)));
      end
      gw_if.overflow_clr_i = ($urandom_range(0, 15) == 0) ? SRC'($urandom()) : '0;
      rst = ($urandom_range(0, 499) == 0);
      tick();
    end
    rst = 1'b0;
    gw_if.claim_req_i    = '0;
    gw_if.complete_req_i = '0;
    gw_if.overflow_clr_i = '0;
    ticks(3);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain actual=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/plic_gateway_multi.md
Name: plic_gateway_multi

Overview:
Next-generation PLIC gateway that converts raw interrupt source lines into pending bits for the PLIC core. Each source has its own trigger mode: level-high, rising edge, falling edge or both edges. Each source has an input synchronizer and a saturating edge counter, so edges that arrive while the source is busy are queued, not lost. Claim/complete handling covers any number of targets. It sits between the external IRQ lines and the PLIC priority/claim logic, and is driven by the PLIC register block.

Parameters:
SRC_COUNT, 32, number of interrupt sources (IDs 1..SRC_COUNT; ID 0 = none)
TGT_COUNT, 2, number of targets (hart contexts)
SRC_WIDTH, $clog2(SRC_COUNT+1), width of a source ID
EDGE_CNT_WIDTH, 3, width of the per-source queued-edge counter (max 2^W-1 queued)
SYNC_STAGES, 2, flip-flop stages in the input synchronizer (>=1)

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
irq_src_i  input  SRC_COUNT  raw source lines, asynchronous
mode_i  input  SRC_COUNT x 2  per-source mode: 00 level-high, 01 rising, 10 falling, 11 both edges
claim_req_i  input  TGT_COUNT  one-cycle claim strobe per target
claim_idx_i  input  TGT_COUNT x SRC_WIDTH  ID being claimed per target
complete_req_i  input  TGT_COUNT  one-cycle complete strobe per target
complete_idx_i  input  TGT_COUNT x SRC_WIDTH  ID being completed per target
overflow_clr_i  input  SRC_COUNT  clears the matching sticky overflow bits
irq_pending_o  output  SRC_COUNT  source pending toward the PLIC core
irq_active_o  output  SRC_COUNT  source claimed and awaiting complete
edge_overflow_o  output  SRC_COUNT  sticky flag: an edge was dropped at counter saturation

Behaviour:
- Reset (rst=1 at a clk edge): all synchronizer flops, edge-detect history, counters, overflow flags and outputs go to 0; every source goes to IDLE. Reset wins over every other event in the same cycle.
- Synchronizer: SYNC_STAGES flops per source give s[i]. An edge register holds the previous value p[i].
- Edge detection: rise = s&~p; fall = ~s&p; edge_det = rise (mode 01), fall (10), rise|fall (11), 0 (00).
- After reset, an input already held high produces one rising edge.
- Request:
  - Level mode: req = s[i]; the counter is held at 0.
  - Edge modes: req = edge_det | (cnt!=0).
- Per-source FSM with states IDLE, PENDING, ACTIVE. pending_o=(state==PENDING) and active_o=(state==ACTIVE), both registered.
  - IDLE -> PENDING when req=1. In edge mode, the consumed request comes from edge_det if present, otherwise cnt decrements by 1.
  - PENDING -> ACTIVE on a valid claim of this ID.
  - ACTIVE -> IDLE on a valid complete of this ID.
  - Level mode: if the line is still high on return to IDLE, it re-pends on the next cycle.
- Counter:
  - edge_det while not consumed (state != IDLE) -> cnt+1.
  - edge_det consumed and a queued decrement in the same cycle cannot both happen; edge_det has priority and cnt is unchanged.
  - At cnt = 2^W-1, a further edge sets edge_overflow_o[i]; cnt stays saturated.
- overflow_clr_i[i] clears the flag on the next edge. If a set and a clear occur in the same cycle, the set wins.
- Mode change: any change of mode_i[i], detected against a registered copy, clears cnt[i] the same cycle. The FSM state is kept.
- Validity: a claim or complete with idx==0 or idx>SRC_COUNT is ignored.
  - A claim is honoured only in PENDING; a complete only in ACTIVE. Otherwise it is ignored with no error.
  - Several targets naming the same ID in one cycle cause one transition.
  - Claim and complete can never both apply to one source in the same cycle.
- Latency:
  - Source change sampled by stage 1 at edge k -> pending_o high after edge k+SYNC_STAGES.
  - Claim strobe at edge k -> pending_o low and active_o high after edge k.
  - Complete at edge k -> active_o low after edge k; a queued edge makes pending_o high after edge k+1.
- Reset mid-operation: counters and active claims are discarded. A target completing after reset is ignored.

Test Plan:
- Reset, then src3 mode 01 with a single 0->1 pulse -> pending_o[2]=1 exactly 2 cycles after sampling. Claim idx 3 from tgt0 -> active_o[2]=1, pending_o[2]=0. Complete -> all 0, cnt=0.
- src5 mode 11, 4 toggles while ACTIVE -> cnt=4. Each complete+claim cycle re-pends; pending is seen 4 more times, then IDLE.
- src1 mode 10, EDGE_CNT_WIDTH=3, 9 falling edges while ACTIVE -> cnt=7, edge_overflow_o[0]=1. overflow_clr_i[0] -> flag 0 next cycle.
- src2 level mode held high: claim, then complete -> pending_o[1]=1 again one cycle after complete. Line dropped before complete -> stays IDLE.
- tgt0 and tgt1 both claim idx 4 in the same cycle -> single ACTIVE. Claims with idx 0 and idx 33 -> no state change anywhere.
- rst asserted with src6 ACTIVE, cnt=3 -> all outputs 0 next cycle. Subsequent complete idx 6 is ignored.
